fpu_add_result_stage: RTL and testbench



---
 rtl/fpu_pkg.sv | 38 +++
 rtl/fpu_ovf_subst.sv | 34 +++
 rtl/fpu_add_result_stage.sv | 167 ++++++++++++++++
 tb/tb_fpu_add_result_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants, rounding modes and FP32 classifier
//
// Purpose : common definitions for the FPU result stages.
// Contents: rounding-mode codes, FP32 overflow constants, class bit indices,
//           and fp32_classify() which returns {nan, inf, zero, denorm}.
package fpu_pkg;

   localparam logic [1:0] RM_RZ  = 2'b00;
   localparam logic [1:0] RM_RNE = 2'b01;
   localparam logic [1:0] RM_RU  = 2'b10;
   localparam logic [1:0] RM_RD  = 2'b11;

   localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
   localparam logic [31:0] FP32_MAX_FIN = 32'h7F7F_FFFF;

   localparam int CLS_NAN    = 3;
   localparam int CLS_INF    = 2;
   localparam int CLS_ZERO   = 1;
   localparam int CLS_DENORM = 0;

   // Sign bit does not affect the class, so only exponent and fraction are taken.
   function automatic logic [3:0] fp32_classify(input logic [30:0] mag);
      logic       e_ones;
      logic       e_zero;
      logic       f_zero;
      logic [3:0] cls;
      e_ones = &mag[30:23];
      e_zero = ~|mag[30:23];
      f_zero = ~|mag[22:0];
      cls             = 4'b0000;
      cls[CLS_NAN]    = e_ones & ~f_zero;
      cls[CLS_INF]    = e_ones &  f_zero;
      cls[CLS_ZERO]   = e_zero &  f_zero;
      cls[CLS_DENORM] = e_zero & ~f_zero;
      return cls;
   endfunction

endpackage

// File: rtl/fpu_ovf_subst.sv
// rtl/fpu_ovf_subst.sv - IEEE-754 overflow value substitution by rounding mode
//
// Purpose : replace an overflowed FP32 result with the value the rounding mode
//           dictates (max finite or infinity, carrying the operation sign).
// Ports   : result     in  32  raw result word (passed through if no overflow)
//           sign       in  1   sign of the overflowed result
//           overflow   in  1   overflow indication
//           round_mode in  2   RZ/RNE/RU/RD
//           subst_result out 32 substituted result word
module fpu_ovf_subst
   import fpu_pkg::*;
(
   input  logic [31:0] result,
   input  logic        sign,
   input  logic        overflow,
   input  logic [1:0]  round_mode,
   output logic [31:0] subst_result
);

   always_comb begin
      subst_result = result;
      if (overflow) begin
         case (round_mode)
            RM_RZ:  subst_result = {sign, FP32_MAX_FIN[30:0]};
            RM_RNE: subst_result = {sign, FP32_POS_INF[30:0]};
            // Directed modes round towards infinity only on their own side.
            RM_RU:  subst_result = sign ? {1'b1, FP32_MAX_FIN[30:0]} : FP32_POS_INF;
            RM_RD:  subst_result = sign ? {1'b1, FP32_POS_INF[30:0]} : FP32_MAX_FIN;
            default: subst_result = result;
         endcase
      end
   end

endmodule

// File: rtl/fpu_add_result_stage.sv
// rtl/fpu_add_result_stage.sv - registered FPU adder result stage with 2-entry FIFO
//
// Purpose : captures adder results (with overflow substitution), buffers them in a
//           2-entry valid/ready FIFO, and keeps sticky error/overflow flags plus an
//           accepted-result counter.
// Config  : FPU_RESULT_CLASSIFY_EN - when defined, a 4-bit class {nan,inf,zero,denorm}
//           is stored per entry and driven on out_class; otherwise out_class = 0.
// Ports   : clk, rst_n (async active-low)
//           in_valid/in_ready, in_result, in_sign, in_error, in_overflow, in_round_mode
//           out_valid/out_ready, out_result, out_error, out_overflow, out_class
//           sticky_err, sticky_ovf, flags_clr, result_cnt[CNT_W]
module fpu_add_result_stage
   import fpu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_result,
   input  logic             in_sign,
   input  logic             in_error,
   input  logic             in_overflow,
   input  logic [1:0]       in_round_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_error,
   output logic             out_overflow,
   output logic [3:0]       out_class,
   output logic             sticky_err,
   output logic             sticky_ovf,
   input  logic             flags_clr,
   output logic [CNT_W-1:0] result_cnt
);

   generate
      if (DEPTH != 2) begin : g_depth_check
         $error("fpu_add_result_stage: DEPTH must be 2");
      end
   endgenerate

   logic [31:0]      mem_result_q [2];
   logic [31:0]      mem_result_d [2];
   logic             mem_err_q    [2];
   logic             mem_err_d    [2];
   logic             mem_ovf_q    [2];
   logic             mem_ovf_d    [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             sticky_err_q, sticky_err_d;
   logic             sticky_ovf_q, sticky_ovf_d;
   logic [CNT_W-1:0] result_cnt_q, result_cnt_d;

   logic             push;
   logic             pop;
   logic [31:0]      push_word;

   fpu_ovf_subst u_ovf_subst (
      .result       (in_result),
      .sign         (in_sign),
      .overflow     (in_overflow),
      .round_mode   (in_round_mode),
      .subst_result (push_word)
   );

   // Ready depends only on stored count: a pop in a full cycle does not free a
   // slot until the next cycle, so there is no out_ready -> in_ready path.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      mem_result_d = mem_result_q;
      mem_err_d    = mem_err_q;
      mem_ovf_d    = mem_ovf_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      result_cnt_d = result_cnt_q;

      if (push) begin
         mem_result_d[wr_ptr_q] = push_word;
         mem_err_d[wr_ptr_q]    = in_error;
         mem_ovf_d[wr_ptr_q]    = in_overflow;
         wr_ptr_d               = ~wr_ptr_q;
         result_cnt_d           = result_cnt_q + CNT_W'(1);
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end

      // A setting push overrides a clear in the same cycle.
      sticky_err_d = (flags_clr ? 1'b0 : sticky_err_q) | (push & in_error);
      sticky_ovf_d = (flags_clr ? 1'b0 : sticky_ovf_q) | (push & in_overflow);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_result_q[i] <= '0;
            mem_err_q[i]    <= 1'b0;
            mem_ovf_q[i]    <= 1'b0;
         end
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         sticky_err_q <= 1'b0;
         sticky_ovf_q <= 1'b0;
         result_cnt_q <= '0;
      end else begin
         mem_result_q <= mem_result_d;
         mem_err_q    <= mem_err_d;
         mem_ovf_q    <= mem_ovf_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         sticky_err_q <= sticky_err_d;
         sticky_ovf_q <= sticky_ovf_d;
         result_cnt_q <= result_cnt_d;
      end
   end

   // Outputs always come from the entry under the read pointer, valid or not.
   assign out_result   = mem_result_q[rd_ptr_q];
   assign out_error    = mem_err_q[rd_ptr_q];
   assign out_overflow = mem_ovf_q[rd_ptr_q];
   assign sticky_err   = sticky_err_q;
   assign sticky_ovf   = sticky_ovf_q;
   assign result_cnt   = result_cnt_q;

`ifdef FPU_RESULT_CLASSIFY_EN
   logic [3:0] mem_cls_q [2];
   logic [3:0] mem_cls_d [2];

   always_comb begin
      mem_cls_d = mem_cls_q;
      if (push) begin
         mem_cls_d[wr_ptr_q] = fp32_classify(push_word[30:0]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_cls_q[i] <= 4'b0000;
         end
      end else begin
         mem_cls_q <= mem_cls_d;
      end
   end

   assign out_class = mem_cls_q[rd_ptr_q];
`else
   assign out_class = 4'b0000;
`endif

endmodule

// File: tb/tb_fpu_add_result_stage.sv
// tb/tb_fpu_add_result_stage.sv - self-checking scoreboard bench for fpu_add_result_stage
module tb_fpu_add_result_stage;

   localparam int CNT_W = 4;
`ifdef FPU_RESULT_CLASSIFY_EN
   localparam logic [3:0] CLS_MASK = 4'hF;
`else
   localparam logic [3:0] CLS_MASK = 4'h0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_result = '0;
   logic             in_sign = 1'b0;
   logic             in_error = 1'b0;
   logic             in_overflow = 1'b0;
   logic [1:0]       in_round_mode = 2'b01;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_result;
   logic             out_error;
   logic             out_overflow;
   logic [3:0]       out_class;
   logic             sticky_err;
   logic             sticky_ovf;
   logic             flags_clr = 1'b0;
   logic [CNT_W-1:0] result_cnt;

   fpu_add_result_stage #(.DEPTH(2), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_result     (in_result),
      .in_sign       (in_sign),
      .in_error      (in_error),
      .in_overflow   (in_overflow),
      .in_round_mode (in_round_mode),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_error     (out_error),
      .out_overflow  (out_overflow),
      .out_class     (out_class),
      .sticky_err    (sticky_err),
      .sticky_ovf    (sticky_ovf),
      .flags_clr     (flags_clr),
      .result_cnt    (result_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic        err;
      logic        ovf;
      logic [3:0]  cls;
   } exp_t;

   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   int               m_cnt = 0;
   logic             m_se = 1'b0;
   logic             m_so = 1'b0;
   logic [CNT_W-1:0] m_rc = '0;

   function automatic logic [31:0] model_word(input logic [31:0] r, input logic s,
                                              input logic ovf, input logic [1:0] rm);
      if (!ovf) return r;
      case (rm)
         2'b00:   return s ? 32'hFF7F_FFFF : 32'h7F7F_FFFF;
         2'b01:   return s ? 32'hFF80_0000 : 32'h7F80_0000;
         2'b10:   return s ? 32'hFF7F_FFFF : 32'h7F80_0000;
         default: return s ? 32'hFF80_0000 : 32'h7F7F_FFFF;
      endcase
   endfunction

   function automatic logic [3:0] model_cls(input logic [31:0] w);
      logic [7:0]  e;
      logic [22:0] f;
      logic [3:0]  c;
      e = w[30:23];
      f = w[22:0];
      c = {(e == 8'hFF) && (f != 0), (e == 8'hFF) && (f == 0),
           (e == 8'h00) && (f == 0), (e == 8'h00) && (f != 0)};
      return c & CLS_MASK;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] r, input logic s, input logic e,
                        input logic o, input logic [1:0] rm, input logic ordy,
                        input logic clr);
      in_valid      = v;
      in_result     = r;
      in_sign       = s;
      in_error      = e;
      in_overflow   = o;
      in_round_mode = rm;
      out_ready     = ordy;
      flags_clr     = clr;
   endtask

   // Called just after a falling edge with this cycle's inputs applied: checks the
   // registered outputs against the model, then advances the model and the clock.
   task automatic cycle();
      exp_t        e;
      logic        do_push;
      logic [31:0] w;
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_cnt != 2});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_cnt != 0});
      chk("sticky_err", {31'b0, sticky_err}, {31'b0, m_se});
      chk("sticky_ovf", {31'b0, sticky_ovf}, {31'b0, m_so});
      chk("result_cnt", {28'b0, result_cnt}, {28'b0, m_rc});
      do_push = in_valid && (m_cnt != 2);
      if (m_cnt != 0 && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk("out_result", out_result, e.res);
            chk("out_error", {31'b0, out_error}, {31'b0, e.err});
            chk("out_overflow", {31'b0, out_overflow}, {31'b0, e.ovf});
            chk("out_class", {28'b0, out_class}, {28'b0, e.cls});
         end
         m_cnt--;
      end
      if (do_push) begin
         w = model_word(in_result, in_sign, in_overflow, in_round_mode);
         sb.push_back('{res: w, err: in_error, ovf: in_overflow, cls: model_cls(w)});
         m_cnt++;
         m_rc = m_rc + 1'b1;
      end
      m_se = (flags_clr ? 1'b0 : m_se) | (do_push & in_error);
      m_so = (flags_clr ? 1'b0 : m_so) | (do_push & in_overflow);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b01, ordy, 1'b0);
      cycle();
   endtask

   initial begin
      // Reset values.
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_error", {31'b0, out_error}, 32'd0);
      chk("rst_out_overflow", {31'b0, out_overflow}, 32'd0);
      chk("rst_out_class", {28'b0, out_class}, 32'd0);
      chk("rst_sticky_err", {31'b0, sticky_err}, 32'd0);
      chk("rst_sticky_ovf", {31'b0, sticky_ovf}, 32'd0);
      chk("rst_result_cnt", {28'b0, result_cnt}, 32'd0);
      rst_n = 1'b1;

      // Pass-through with one-cycle latency.
      drive(1'b1, 32'h3FC0_0000, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
      cycle();
      chk("pass_out_valid", {31'b0, out_valid}, 32'd1);
      chk("pass_out_result", out_result, 32'h3FC0_0000);
      chk("pass_result_cnt", {28'b0, result_cnt}, 32'd1);
      idle(1'b1);

      // Overflow substitution, negative sign in all four modes, then positive RU/RD.
      for (int rm = 0; rm < 4; rm++) begin
         drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 2'(rm), 1'b1, 1'b0);
         cycle();
      end
      drive(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
      cycle();
      idle(1'b1);
      chk("ovf_sticky_ovf", {31'b0, sticky_ovf}, 32'd1);

      // Class coverage: NaN, +0, denorm, -0 (with error), normal.
      drive(1'b1, 32'h7FC0_0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0); cycle();
      drive(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0); cycle();
      drive(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0); cycle();
      drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0); cycle();
      drive(1'b1, 32'hC120_0000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0); cycle();
      idle(1'b1);

      // Backpressure: A, B accepted, C held until a slot frees after the full cycle.
      drive(1'b1, 32'h4000_000A, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h4000_000B, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0); cycle();
      chk("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
      drive(1'b1, 32'h4000_000C, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0); cycle();
      cycle();
      drive(1'b1, 32'h4000_000C, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0); cycle();
      chk("bp_no_push_on_full_pop", {28'b0, result_cnt}, {28'b0, m_rc});
      cycle();
      idle(1'b1);
      idle(1'b1);

      // Sticky clear collides with an error push: set wins, then a lone clear.
      idle(1'b1);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1); cycle();
      chk("sticky_cleared", {31'b0, sticky_err}, 32'd0);
      drive(1'b1, 32'h4040_0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1); cycle();
      chk("sticky_set_wins", {31'b0, sticky_err}, 32'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1); cycle();
      chk("sticky_clr_alone", {31'b0, sticky_err}, 32'd0);
      idle(1'b1);

      // Asynchronous reset with the FIFO full and sticky flags set.
      drive(1'b1, 32'h4100_0000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0); cycle();
      chk("prerst_full", {31'b0, in_ready}, 32'd0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("arst_result_cnt", {28'b0, result_cnt}, 32'd0);
      chk("arst_sticky_err", {31'b0, sticky_err}, 32'd0);
      chk("arst_sticky_ovf", {31'b0, sticky_ovf}, 32'd0);
      chk("arst_out_result", out_result, 32'd0);
      sb.delete();
      m_cnt = 0;
      m_se  = 1'b0;
      m_so  = 1'b0;
      m_rc  = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Counter wrap: 17 pushes on a 4-bit counter.
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, $urandom, 1'(i), 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
         cycle();
      end
      idle(1'b1);
      chk("wrap_result_cnt", {28'b0, result_cnt}, 32'd1);
      chk("sb_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
